imem_loader: RTL and testbench

- Boot-time writer for the instruction memory's write port (write enable, write data, address).
- Receives a program as a big-endian byte stream over a valid/ready handshake and packs it into 32-bit words.
- Writes each word at consecutive word addresses from BASE_ADDR and holds the CPU in reset until the load completes.
- Sits between an external byte source (UART receiver, test host) and the instruction memory; its cpu_hold output is ORed into the core reset.

---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader_byte_packer.sv | 34 +++
 rtl/imem_loader.sv | 117 +++++++++++
 tb/tb_imem_loader.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

  typedef enum logic [1:0] {
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  localparam int WORD_BYTES          = 4;
  localparam int DEPTH_WORDS_DEFAULT = 256;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, imem write port and status bundle for the loader
interface imem_loader_if;

  logic [7:0]  byte_data_ld_i;
  logic        byte_valid_ld_i;
  logic        byte_ready_ld_o;
  logic        start_ld_i;
  logic [31:0] addr_imem_ld_o;
  logic [31:0] wr_instr_imem_ld_o;
  logic        wr_en_imem_ld_o;
  logic        cpu_hold_ld_o;
  logic        done_ld_o;
  logic        err_ld_o;
  logic [31:0] words_loaded_ld_o;

  // master is the loader itself; slave is the byte source / memory / core side
  modport master (
    input  byte_data_ld_i, byte_valid_ld_i, start_ld_i,
    output byte_ready_ld_o, addr_imem_ld_o, wr_instr_imem_ld_o, wr_en_imem_ld_o,
    output cpu_hold_ld_o, done_ld_o, err_ld_o, words_loaded_ld_o
  );

  modport slave (
    output byte_data_ld_i, byte_valid_ld_i, start_ld_i,
    input  byte_ready_ld_o, addr_imem_ld_o, wr_instr_imem_ld_o, wr_en_imem_ld_o,
    input  cpu_hold_ld_o, done_ld_o, err_ld_o, words_loaded_ld_o
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - MSB-first byte to 32-bit word packer
// word/word_valid are presented combinationally on the cycle the 4th byte is accepted.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shift;
  logic [1:0]  count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      count <= '0;
    end else if (clear) begin
      shift <= '0;
      count <= '0;
    end else if (in_valid) begin
      shift <= {shift[15:0], in_data};
      count <= count + 2'd1;
    end
  end

  assign word       = {shift, in_data};
  assign word_valid = in_valid && (count == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a length-prefixed byte stream into instruction memory
// Holds the core in reset until the last word is committed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.master bus
);

  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

  state_t      state;
  logic        ready;
  logic        hold;
  logic        done;
  logic        err;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wr_instr;
  logic [31:0] words_loaded;
  logic [31:0] len;

  logic        accept;
  logic        restart;
  logic [31:0] word;
  logic        word_valid;

  assign accept  = bus.byte_valid_ld_i && ready;
  assign restart = bus.start_ld_i && ((state == S_DONE) || (state == S_ERR));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (reset),
    .clear      (restart),
    .in_valid   (accept),
    .in_data    (bus.byte_data_ld_i),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_LEN;
      ready        <= 1'b1;
      hold         <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      wr_en        <= 1'b0;
      addr         <= BASE_ADDR;
      wr_instr     <= '0;
      words_loaded <= '0;
      len          <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_LEN: begin
          if (word_valid) begin
            len <= word;
            if (word == 32'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
              ready <= 1'b0;
            end else if (word > DEPTH_LIMIT) begin
              state <= S_ERR;
              err   <= 1'b1;
              ready <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (word_valid) begin
            wr_instr     <= word;
            wr_en        <= 1'b1;
            addr         <= BASE_ADDR + {words_loaded[29:0], 2'b00};
            words_loaded <= words_loaded + 32'd1;
            if (words_loaded + 32'd1 == len) begin
              state <= S_DONE;
              done  <= 1'b1;
              ready <= 1'b0;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (restart) begin
            state        <= S_LEN;
            ready        <= 1'b1;
            hold         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            addr         <= BASE_ADDR;
          end else if (state == S_DONE) begin
            // done was raised on the previous edge, so the last write is already in memory
            hold <= 1'b0;
          end
        end
        default: state <= S_LEN;
      endcase
    end
  end

  assign bus.byte_ready_ld_o    = ready;
  assign bus.cpu_hold_ld_o      = hold;
  assign bus.done_ld_o          = done;
  assign bus.err_ld_o           = err;
  assign bus.wr_en_imem_ld_o    = wr_en;
  assign bus.addr_imem_ld_o     = addr;
  assign bus.wr_instr_imem_ld_o = wr_instr;
  assign bus.words_loaded_ld_o  = words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with two base addresses
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if ifc0 ();
  imem_loader_if ifc1 ();

  imem_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(256)) dut0 (.clk(clk), .reset(rst), .bus(ifc0));
  imem_loader #(.BASE_ADDR(32'h0000_0400), .DEPTH_WORDS(256)) dut1 (.clk(clk), .reset(rst), .bus(ifc1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_a0[$], exp_d0[$], exp_a1[$], exp_d1[$];
  logic [31:0] prog[$];
  int          last_wr_cyc[2];
  int          wr_gap[2];
  logic        prev_done[2];
  logic        pend_hold[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_of(input int u);
    return (u == 0) ? 32'h0 : 32'h400;
  endfunction

  // 0 ready, 1 hold, 2 done, 3 err, 4 words_loaded, 5 addr, 6 wr_en, 7 wr_instr
  function automatic logic [31:0] st(input int u, input int f);
    if (u == 0) begin
      case (f)
        0: return 32'(ifc0.byte_ready_ld_o);
        1: return 32'(ifc0.cpu_hold_ld_o);
        2: return 32'(ifc0.done_ld_o);
        3: return 32'(ifc0.err_ld_o);
        4: return ifc0.words_loaded_ld_o;
        5: return ifc0.addr_imem_ld_o;
        6: return 32'(ifc0.wr_en_imem_ld_o);
        default: return ifc0.wr_instr_imem_ld_o;
      endcase
    end else begin
      case (f)
        0: return 32'(ifc1.byte_ready_ld_o);
        1: return 32'(ifc1.cpu_hold_ld_o);
        2: return 32'(ifc1.done_ld_o);
        3: return 32'(ifc1.err_ld_o);
        4: return ifc1.words_loaded_ld_o;
        5: return ifc1.addr_imem_ld_o;
        6: return 32'(ifc1.wr_en_imem_ld_o);
        default: return ifc1.wr_instr_imem_ld_o;
      endcase
    end
  endfunction

  task automatic drv(input int u, input logic v, input logic [7:0] d);
    if (u == 0) begin
      ifc0.byte_valid_ld_i = v;
      ifc0.byte_data_ld_i  = d;
    end else begin
      ifc1.byte_valid_ld_i = v;
      ifc1.byte_data_ld_i  = d;
    end
  endtask

  task automatic drv_start(input int u, input logic s);
    if (u == 0) ifc0.start_ld_i = s;
    else        ifc1.start_ld_i = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte after `gap` idle cycles and returns once it has been accepted.
  task automatic send_byte(input int u, input logic [7:0] b, input int gap);
    logic r;
    bit   ok;
    if (gap > 0) begin
      drv(u, 1'b0, 8'h00);
      repeat (gap) tick();
    end
    drv(u, 1'b1, b);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      r = st(u, 0)[0];
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: unit %0d byte %h not accepted", u, b);
    end
  endtask

  task automatic send_word(input int u, input logic [31:0] w, input int mode);
    for (int k = 3; k >= 0; k--) begin
      int gap;
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
      send_byte(u, w[8*k +: 8], gap);
    end
  endtask

  task automatic start_pulse(input int u);
    drv_start(u, 1'b1);
    tick();
    drv_start(u, 1'b0);
    chk("restart_done", st(u, 2), 0);
    chk("restart_err", st(u, 3), 0);
    chk("restart_hold", st(u, 1), 1);
    chk("restart_ready", st(u, 0), 1);
    chk("restart_words", st(u, 4), 0);
    chk("restart_addr", st(u, 5), base_of(u));
  endtask

  // Loads a length-n program (prog, padded with random words); mode 0 valid held, 1 toggling, 2 random gaps.
  task automatic do_load(input int u, input logic [31:0] n, input int mode);
    bit  is_err;
    bit  got;
    is_err = (n > 32'd256);
    if (!is_err) begin
      while (prog.size() < int'(n)) prog.push_back($urandom);
      for (int i = 0; i < int'(n); i++) begin
        if (u == 0) begin
          exp_a0.push_back(base_of(u) + 32'(4 * i));
          exp_d0.push_back(prog[i]);
        end else begin
          exp_a1.push_back(base_of(u) + 32'(4 * i));
          exp_d1.push_back(prog[i]);
        end
      end
    end
    send_word(u, n, mode);
    if (!is_err) begin
      for (int i = 0; i < int'(n); i++) send_word(u, prog[i], mode);
    end
    drv(u, 1'b0, 8'h00);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (st(u, 2)[0] || st(u, 3)[0]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("load_finished", 32'(got), 1);
    if (is_err) begin
      chk("err_flag", st(u, 3), 1);
      chk("err_done_low", st(u, 2), 0);
      chk("err_ready_low", st(u, 0), 0);
      repeat (3) tick();
      chk("err_hold_high", st(u, 1), 1);
      chk("err_words", st(u, 4), 0);
    end else begin
      chk("done_flag", st(u, 2), 1);
      chk("done_err_low", st(u, 3), 0);
      chk("done_words", st(u, 4), n);
      repeat (2) tick();
      chk("done_hold_low", st(u, 1), 0);
      chk("done_ready_low", st(u, 0), 0);
    end
    chk("pending_writes", 32'((u == 0) ? exp_a0.size() : exp_a1.size()), 0);
    prog.delete();
  endtask

  // Monitor: every write strobe is popped against the scoreboard; also tracks done/hold ordering.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      for (int u = 0; u < 2; u++) begin
        logic [31:0] ea, ed;
        int          left;
        logic        dn;
        dn = st(u, 2)[0];
        if (st(u, 6)[0]) begin
          if ((u == 0 && exp_a0.size() == 0) || (u == 1 && exp_a1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: unit %0d addr %h data %h", u, st(u, 5), st(u, 7));
          end else begin
            if (u == 0) begin
              ea = exp_a0.pop_front(); ed = exp_d0.pop_front(); left = exp_a0.size();
            end else begin
              ea = exp_a1.pop_front(); ed = exp_d1.pop_front(); left = exp_a1.size();
            end
            chk("wr_addr", st(u, 5), ea);
            chk("wr_data", st(u, 7), ed);
            chk("done_with_last_write", 32'(dn), 32'(left == 0));
          end
          wr_gap[u]      = cyc - last_wr_cyc[u];
          last_wr_cyc[u] = cyc;
        end
        if (pend_hold[u]) begin
          chk("hold_falls_after_done", st(u, 1), 0);
          pend_hold[u] = 1'b0;
        end
        if (dn && !prev_done[u]) begin
          chk("hold_at_done_rise", st(u, 1), 1);
          pend_hold[u] = 1'b1;
        end
        prev_done[u] = dn;
      end
    end else begin
      prev_done[0] = 1'b0; prev_done[1] = 1'b0;
      pend_hold[0] = 1'b0; pend_hold[1] = 1'b0;
    end
  end

  initial begin
    drv(0, 1'b0, 8'h00);
    drv(1, 1'b0, 8'h00);
    drv_start(0, 1'b0);
    drv_start(1, 1'b0);
    last_wr_cyc[0] = 0; last_wr_cyc[1] = 0;
    wr_gap[0] = 0; wr_gap[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_ready", st(u, 0), 1);
      chk("rst_hold", st(u, 1), 1);
      chk("rst_done", st(u, 2), 0);
      chk("rst_err", st(u, 3), 0);
      chk("rst_words", st(u, 4), 0);
      chk("rst_addr", st(u, 5), base_of(u));
      chk("rst_wr_en", st(u, 6), 0);
      chk("rst_wr_instr", st(u, 7), 0);
    end
    rst = 1'b0;
    tick();

    do_load(1, 3, 2);

    prog = '{32'h2008_0005, 32'hAC08_0000};
    do_load(0, 2, 0);
    chk("b2b_write_spacing", 32'(wr_gap[0]), 4);

    start_pulse(0);
    prog = '{32'h2008_0005, 32'hAC08_0000};
    do_load(0, 2, 1);

    start_pulse(0);
    do_load(0, 0, 0);

    start_pulse(0);
    do_load(0, 32'h0000_0101, 0);
    start_pulse(0);
    do_load(0, 1, 2);

    // abandon a 2-word load after 6 bytes, then reset mid-flight
    start_pulse(0);
    send_word(0, 32'd2, 0);
    send_byte(0, 8'h11, 0);
    send_byte(0, 8'h22, 0);
    drv(0, 1'b0, 8'h00);
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_words", st(0, 4), 0);
    chk("midrst_ready", st(0, 0), 1);
    chk("midrst_hold", st(0, 1), 1);
    prog = '{32'hDEAD_BEEF};
    do_load(0, 1, 0);

    for (int t = 0; t < 8; t++) begin
      start_pulse(0);
      if (t == 5) do_load(0, 32'($urandom_range(257, 4000)), 2);
      else        do_load(0, 32'($urandom_range(1, 12)), 2);
    end

    start_pulse(0);
    do_load(0, 256, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
